// File: rtl/mem_arb_defs.sv
// Definitions shared by the memory arbiter: FSM state encoding, requester
// indices, the default WAIT timeout and the owner-to-one-hot helper.
package mem_arb_defs;

  localparam int TIMEOUT_CYC_DEF = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_TX  = 2'd0,
    REQ_WR  = 2'd1,
    REQ_SEL = 2'd2
  } req_e;

  function automatic logic [2:0] req_onehot(req_e r);
    logic [2:0] oh;
    oh = '0;
    case (r)
      REQ_TX:  oh = 3'b001;
      REQ_WR:  oh = 3'b010;
      REQ_SEL: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between the write and select paths.
// The pointer moves only when the arbiter finishes a wr or sel access.
module mem_arb_rr (
  input  logic clk,
  input  logic reset,
  input  logic wr_req,
  input  logic sel_req,
  input  logic update,
  input  logic served_sel,
  output logic pick_wr,
  output logic pick_sel
);

  // Set when sel is next in line, i.e. wr was served last.
  logic favour_sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      favour_sel <= 1'b0;
    end else if (update) begin
      favour_sel <= !served_sel;
    end
  end

  always_comb begin
    pick_wr  = wr_req && (!sel_req || !favour_sel);
    pick_sel = sel_req && (!wr_req || favour_sel);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the tag's TX, WRITE and SELECT paths:
// fixed TX priority with burst lock, wr/sel round-robin, ack timeout.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_req,
  input  logic        tx_lock,
  input  logic [1:0]  tx_bank,
  input  logic [7:0]  tx_ptr,
  input  logic        wr_req,
  input  logic [1:0]  wr_bank,
  input  logic [7:0]  wr_ptr,
  input  logic [15:0] wr_data,
  input  logic        sel_req,
  input  logic [1:0]  sel_bank,
  input  logic [7:0]  sel_ptr,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state, state_nx;
  req_e          owner, win;
  logic [1:0]    lat_bank;
  logic [7:0]    lat_ptr;
  logic [15:0]   lat_data;
  logic [TW-1:0] timer;
  logic          timed_out;
  logic          any_req, burst, expired, pick_wr, pick_sel;

  assign any_req  = tx_req | wr_req | sel_req;
  assign burst    = (owner == REQ_TX) && tx_lock && tx_req;
  assign expired  = (timer == TW'(TIMEOUT_CYC));
  assign mem_bank = lat_bank;
  assign mem_addr = lat_ptr;

  mem_arb_rr u_rr (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .sel_req    (sel_req),
    .update     ((state == ST_DONE) && (owner != REQ_TX)),
    .served_sel (owner == REQ_SEL),
    .pick_wr    (pick_wr),
    .pick_sel   (pick_sel)
  );

  always_comb begin
    if (tx_req)        win = REQ_TX;
    else if (pick_wr)  win = REQ_WR;
    else if (pick_sel) win = REQ_SEL;
    else               win = REQ_TX;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nx  = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      ST_IDLE: if (any_req) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        gnt    = req_onehot(owner);
        mem_en = 1'b1;
        if (owner == REQ_WR) begin
          mem_we    = 1'b1;
          mem_wdata = lat_data;
        end
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        gnt = req_onehot(owner);
        if (mem_ack || expired) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = req_onehot(owner);
        err      = timed_out;
        state_nx = burst ? ST_ISSUE : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      owner     <= REQ_TX;
      lat_bank  <= '0;
      lat_ptr   <= '0;
      lat_data  <= '0;
      timer     <= '0;
      timed_out <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (any_req) begin
          owner <= win;
          unique case (win)
            REQ_WR: begin
              lat_bank <= wr_bank;
              lat_ptr  <= wr_ptr;
              lat_data <= wr_data;
            end
            REQ_SEL: begin
              lat_bank <= sel_bank;
              lat_ptr  <= sel_ptr;
              lat_data <= '0;
            end
            default: begin
              lat_bank <= tx_bank;
              lat_ptr  <= tx_ptr;
              lat_data <= '0;
            end
          endcase
        end
        ST_ISSUE: begin
          timer     <= TW'(1);
          timed_out <= 1'b0;
        end
        ST_WAIT: begin
          // An ack on the expiry cycle still counts as a normal completion.
          if (mem_ack) begin
            if (owner != REQ_WR) rdata <= mem_rdata;
          end else if (expired) begin
            timed_out <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          timer <= '0;
          if (burst) begin
            lat_bank <= tx_bank;
            lat_ptr  <= tx_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder with programmable ack
// latency, and a scoreboard of expected issues and completions.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_req, tx_lock, wr_req, sel_req;
  logic [1:0]  tx_bank, wr_bank, sel_bank;
  logic [7:0]  tx_ptr, wr_ptr, sel_ptr;
  logic [15:0] wr_data;
  logic [2:0]  gnt, done;
  logic        err, mem_en, mem_we, mem_ack;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_addr;

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .tx_req(tx_req), .tx_lock(tx_lock), .tx_bank(tx_bank), .tx_ptr(tx_ptr),
    .wr_req(wr_req), .wr_bank(wr_bank), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .sel_req(sel_req), .sel_bank(sel_bank), .sel_ptr(sel_ptr),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        we;
    logic [1:0]  bank;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [2:0]  done;
    logic        err;
    logic [15:0] rdata;
  } dn_t;

  iss_t        iss_q[$];
  dn_t         dn_q[$];
  iss_t        ei;
  dn_t         ed;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_en_cyc, last_done_cyc, c0, k;
  int          t[4];
  logic [15:0] mem_model [4][256];
  logic [15:0] exp_rdata;
  int          ack_lat;
  logic        stray_ack;
  bit          pend;
  int          wcnt;
  logic [15:0] pend_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic [2:0] g, input logic we, input logic [1:0] b,
                          input logic [7:0] a, input logic [15:0] d);
    iss_t e;
    e = '{gnt: g, we: we, bank: b, addr: a, wdata: d};
    iss_q.push_back(e);
  endtask

  task automatic push_dn(input logic [2:0] d, input logic e, input logic [15:0] r);
    dn_t x;
    x = '{done: d, err: e, rdata: r};
    dn_q.push_back(x);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (iss_q.size() == 0 && dn_q.size() == 0) break;
    end
    check("drain", iss_q.size() + dn_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_bank"}, mem_bank, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Memory responder: ack arrives ack_lat cycles after the mem_en cycle (0 = never).
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'hDEAD;
    pend      = 1'b0;
    wcnt      = 0;
    pend_data = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (!reset) begin
        pend = 1'b0;
      end else if (pend) begin
        if (wcnt <= 1) begin
          mem_ack   = 1'b1;
          mem_rdata = pend_data;
          pend      = 1'b0;
        end else begin
          wcnt--;
        end
      end
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hBAD0;
      end
      if (mem_en && ack_lat > 0) begin
        pend      = 1'b1;
        wcnt      = ack_lat;
        pend_data = mem_model[mem_bank][mem_addr];
      end
      if (mem_en && mem_we) mem_model[mem_bank][mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      last_en_cyc = cyc;
      if (iss_q.size() == 0) begin
        check("issue_queue", iss_q.size(), 1);
      end else begin
        ei = iss_q.pop_front();
        check("iss_gnt", gnt, ei.gnt);
        check("iss_we", mem_we, ei.we);
        check("iss_bank", mem_bank, ei.bank);
        check("iss_addr", mem_addr, ei.addr);
        check("iss_wdata", mem_wdata, ei.wdata);
      end
    end
    if (done != 3'b000) begin
      last_done_cyc = cyc;
      if (dn_q.size() == 0) begin
        check("done_queue", dn_q.size(), 1);
      end else begin
        ed = dn_q.pop_front();
        check("dn_done", done, ed.done);
        check("dn_err", err, ed.err);
        check("dn_rdata", rdata, ed.rdata);
      end
    end else if (err) begin
      check("err_without_done", err, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        mem_model[b][a] = 16'(b * 4096 + a * 16 + 3);
    mem_model[1][2] = 16'h3000;
    reset = 1'b0; tx_req = 0; tx_lock = 0; wr_req = 0; sel_req = 0;
    tx_bank = 0; tx_ptr = 0; wr_bank = 0; wr_ptr = 0; wr_data = 0;
    sel_bank = 0; sel_ptr = 0; ack_lat = 1; stray_ack = 0;
    exp_rdata = '0;
    tick(); tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single TX read: exact latency and inputs changing after the latch.
    push_iss(3'b001, 0, 2'd1, 8'h02, 16'h0);
    exp_rdata = mem_model[1][8'h02];
    push_dn(3'b001, 0, exp_rdata);
    c0 = cyc;
    tx_bank = 2'd1; tx_ptr = 8'h02; tx_req = 1;
    tick();
    tx_req = 0; tx_bank = 2'd3; tx_ptr = 8'hFF;
    drain(20);
    check("tx_en_latency", last_en_cyc - c0, 1);
    check("tx_done_latency", last_done_cyc - c0, 3);
    check("tx_rdata", rdata, 16'h3000);

    // Ack while idle is ignored.
    stray_ack = 1;
    tick();
    stray_ack = 0;
    tick(); tick();
    check("stray_rdata", rdata, exp_rdata);
    check("stray_gnt", gnt, 0);

    // wr and sel held together: alternate starting with wr.
    ack_lat = 2;
    wr_bank = 2'd2; wr_ptr = 8'h10; wr_data = 16'hA5A5;
    sel_bank = 2'd3; sel_ptr = 8'h20;
    for (int i = 0; i < 2; i++) begin
      push_iss(3'b010, 1, 2'd2, 8'h10, 16'hA5A5);
      push_dn(3'b010, 0, exp_rdata);
      push_iss(3'b100, 0, 2'd3, 8'h20, 16'h0);
      exp_rdata = mem_model[3][8'h20];
      push_dn(3'b100, 0, exp_rdata);
    end
    wr_req = 1; sel_req = 1; k = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_en) k++;
      if (k == 4) break;
    end
    wr_req = 0; sel_req = 0;
    check("rr_issue_count", k, 4);
    drain(40);

    // All three raised together: tx, then wr, then sel.
    ack_lat = 3;
    tx_bank = 2'd1; tx_ptr = 8'h03;
    wr_bank = 2'd1; wr_ptr = 8'h05; wr_data = 16'hBEEF;
    sel_bank = 2'd0; sel_ptr = 8'h07;
    exp_rdata = mem_model[1][8'h03];
    push_iss(3'b001, 0, 2'd1, 8'h03, 16'h0);
    push_dn(3'b001, 0, exp_rdata);
    push_iss(3'b010, 1, 2'd1, 8'h05, 16'hBEEF);
    push_dn(3'b010, 0, exp_rdata);
    exp_rdata = mem_model[0][8'h07];
    push_iss(3'b100, 0, 2'd0, 8'h07, 16'h0);
    push_dn(3'b100, 0, exp_rdata);
    tx_req = 1; wr_req = 1; sel_req = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_en && gnt[0]) tx_req = 0;
      if (mem_en && gnt[1]) wr_req = 0;
      if (mem_en && gnt[2]) sel_req = 0;
      if (!tx_req && !wr_req && !sel_req) break;
    end
    drain(40);

    // Locked TX burst over ptr 0..3 holds off a pending write.
    ack_lat = 1;
    tx_bank = 2'd0; tx_ptr = 8'h00; tx_lock = 1;
    wr_bank = 2'd0; wr_ptr = 8'h09; wr_data = 16'hC0DE;
    for (int i = 0; i < 4; i++) begin
      push_iss(3'b001, 0, 2'd0, 8'(i), 16'h0);
      push_dn(3'b001, 0, mem_model[0][i]);
    end
    exp_rdata = mem_model[0][3];
    push_iss(3'b010, 1, 2'd0, 8'h09, 16'hC0DE);
    push_dn(3'b010, 0, exp_rdata);
    tx_req = 1; wr_req = 1; k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mem_en && gnt == 3'b001 && k < 4) begin
        t[k] = cyc;
        k++;
        if (k < 4) tx_ptr = 8'(k);
        else begin
          tx_req = 0;
          tx_lock = 0;
        end
      end
      if (mem_en && gnt == 3'b010) wr_req = 0;
      if (iss_q.size() == 0 && dn_q.size() == 0) break;
    end
    check("burst_count", k, 4);
    for (int i = 1; i < 4; i++) check("burst_gap", t[i] - t[i-1], 3);
    check("burst_wr_after", last_en_cyc - t[3], 4);
    drain(20);

    // Timeout with no ack, then ack on the last WAIT cycle.
    ack_lat = 0;
    tx_bank = 2'd2; tx_ptr = 8'h40;
    push_iss(3'b001, 0, 2'd2, 8'h40, 16'h0);
    push_dn(3'b001, 1, exp_rdata);
    c0 = cyc;
    tx_req = 1;
    tick();
    tx_req = 0;
    drain(30);
    check("timeout_done_latency", last_done_cyc - c0, 2 + TO);
    check("timeout_rdata", rdata, exp_rdata);
    ack_lat = TO;
    exp_rdata = mem_model[2][8'h40];
    push_iss(3'b001, 0, 2'd2, 8'h40, 16'h0);
    push_dn(3'b001, 0, exp_rdata);
    c0 = cyc;
    tx_req = 1;
    tick();
    tx_req = 0;
    drain(30);
    check("late_ack_done_latency", last_done_cyc - c0, 2 + TO);
    check("late_ack_rdata", rdata, exp_rdata);

    // Reset during WAIT of a sel read aborts silently.
    ack_lat = 0;
    sel_bank = 2'd1; sel_ptr = 8'h11;
    push_iss(3'b100, 0, 2'd1, 8'h11, 16'h0);
    sel_req = 1;
    tick();
    sel_req = 0;
    tick(); tick();
    check("pre_reset_gnt", gnt, 3'b100);
    reset = 0;
    tick();
    check_all_zero("mid_reset");
    reset = 1;
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_pending", iss_q.size() + dn_q.size(), 0);
    ack_lat = 1;
    exp_rdata = mem_model[1][8'h11];
    push_iss(3'b100, 0, 2'd1, 8'h11, 16'h0);
    push_dn(3'b100, 0, exp_rdata);
    sel_req = 1;
    tick();
    sel_req = 0;
    drain(20);
    check("post_reset_rdata", rdata, exp_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 200, is the number of WAIT cycles without mem_ack before the block aborts.
REQ-002 clk  in  1  tag master clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; reset==0 sampled on a clk edge resets the block.
REQ-004 tx_req  in  1  TX serializer (EPC/READ backscatter) requests one word.
REQ-005 tx_lock  in  1  TX requests burst ownership across consecutive words.
REQ-006 tx_bank  in  2  TX memory bank.
REQ-007 tx_ptr  in  8  TX word address.
REQ-008 wr_req  in  1  WRITE-command path requests one word write.
REQ-009 wr_bank  in  2  write bank.
REQ-010 wr_ptr  in  8  write word address.
REQ-011 wr_data  in  16  write word.
REQ-012 sel_req  in  1  SELECT mask-compare path requests one word read.
REQ-013 sel_bank  in  2  select bank.
REQ-014 sel_ptr  in  8  select word address.
REQ-015 gnt  out  3  one-hot owner {sel,wr,tx}, held ISSUE through WAIT.
REQ-016 done  out  3  one-cycle completion pulse per requester, same bit order as gnt.
REQ-017 err  out  1  one-cycle pulse, coincident with done, when the access timed out.
REQ-018 rdata  out  16  last read word, valid from the done cycle until the next read completes.
REQ-019 mem_en  out  1  one-cycle access strobe.  mem_we  out  1  write qualifier.  mem_bank  out  2.  mem_addr  out  8.  mem_wdata  out  16.
REQ-020 mem_rdata  in  16  read word.  mem_ack  in  1  access complete, latency 1..N cycles after mem_en.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: if any req is high, pick the winner, latch its bank/ptr/data, go to ISSUE; else stay.
REQ-023 Priority: tx SHALL win whenever tx_req is high; wr vs sel SHALL alternate round-robin when both are high, last-served loses.
REQ-024 ISSUE: gnt asserted, mem_en=1 for exactly this cycle, mem_we=1 only for wr, mem_wdata=latched wr_data for wr else 0; next state WAIT.
REQ-025 WAIT: mem_ack==1 -> capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
REQ-026 WAIT: timer counts from 1; at TIMEOUT_CYC cycles without ack -> err=1 in DONE, rdata unchanged.
REQ-027 mem_ack and timer expiry in the same cycle: ack wins, no err.
REQ-028 mem_ack outside WAIT SHALL be ignored.
REQ-029 DONE: done[owner]=1 for one cycle, gnt=0. If owner==tx, tx_lock==1 and tx_req==1, latch new tx_bank/tx_ptr and go to ISSUE (burst); otherwise go to IDLE.
REQ-030 A burst SHALL block wr/sel until tx_lock or tx_req falls in a DONE cycle.
REQ-031 Latency: req first high in IDLE at cycle 0 -> ISSUE/gnt/mem_en at cycle 1 -> earliest ack at cycle 2 -> done/rdata at cycle 3.
REQ-032 Requester inputs changing after the latch SHALL NOT affect the in-flight access; dropping req mid-access still produces done.
REQ-033 The round-robin pointer SHALL update only in DONE of a wr or sel access.

Reset
REQ-034 On reset: state IDLE, gnt=0, done=0, err=0, rdata=0, mem_en=0, mem_we=0, mem_bank=0, mem_addr=0, mem_wdata=0, timer=0, round-robin favours wr.
REQ-035 Reset mid-access SHALL abort with no done/err pulse; mem_en low from the next edge.

Structure
REQ-036 State encodings, requester indices (TX=0, WR=1, SEL=2) and the TIMEOUT_CYC default SHALL live in a shared defines include, mem_arb_defs.
REQ-037 The wr/sel 2-way round-robin pick with pointer SHALL be a sub-module mem_arb_rr; everything else stays flat.

Verification
REQ-038 tx_req with tx_bank=1, tx_ptr=8'h02; mem_ack 1 cycle after mem_en with mem_rdata=16'h3000 -> mem_en cycle 1, done=3'b001 cycle 3, rdata=16'h3000.
REQ-039 wr_req and sel_req both held high for 4 accesses -> grants wr,sel,wr,sel; one mem_we=1 per wr access carrying wr_data.
REQ-040 tx_req, wr_req and sel_req raised on the same cycle -> tx first, then wr, then sel.
REQ-041 tx_lock=1, tx_req=1, ptr 0..3 with wr_req pending -> four back-to-back tx accesses with no IDLE between, wr granted only after tx_lock drops.
REQ-042 TIMEOUT_CYC=4, mem_ack never asserted -> done and err pulse together 4 cycles into WAIT, rdata unchanged; repeat with ack on cycle 4 -> no err.
REQ-043 reset=0 during WAIT of a sel read -> no done, all outputs 0 next cycle; next request is serviced normally.
